// File: rtl/fetch_unit.sv
// Multicycle instruction fetch: PC register, req/ack instruction-memory handshake, one-deep instr hold.
// Computes next PC at retire (jump > branch > sequential); a FETCH with no ack for TIMEOUT_CYCLES latches a sticky fault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        pcsrc,
  input  logic        jump,
  input  logic [31:0] signimm,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic        fetch_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic               instr_valid_q, instr_valid_d;
  logic               imem_req_q, imem_req_d;
  logic               fetch_err_q, fetch_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic [31:0]        next_pc_raw;
  logic               retire;

  assign pcplus4 = pc_q + 32'd4;
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign retire  = instr_valid_q & instr_ready;

  // All targets are word-aligned by construction; the mask keeps that true regardless.
  always_comb begin
    next_pc_raw = pcplus4;
    if (jump) begin
      next_pc_raw = {pcplus4[31:28], instr_q[25:0], 2'b00};
    end else if (pcsrc) begin
      next_pc_raw = pcplus4 + (signimm << 2);
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    imem_req_d    = imem_req_q;
    fetch_err_d   = fetch_err_q;
    cnt_d         = cnt_q;
    case (state_q)
      IDLE: begin
        state_d    = FETCH;
        imem_req_d = 1'b1;
        cnt_d      = '0;
      end
      FETCH: begin
        if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          imem_req_d    = 1'b0;
          state_d       = HOLD;
        end else begin
          cnt_d = cnt_inc;
          if ((TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_LIM)) begin
            imem_req_d  = 1'b0;
            fetch_err_d = 1'b1;
            state_d     = ERR;
          end
        end
      end
      HOLD: begin
        if (retire) begin
          pc_d          = next_pc_raw & ~32'h3;
          instr_valid_d = 1'b0;
          imem_req_d    = 1'b1;
          cnt_d         = '0;
          state_d       = FETCH;
        end
      end
      ERR: begin
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
        fetch_err_d   = 1'b1;
      end
      default: begin
        state_d    = IDLE;
        imem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC_ALIGNED;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      fetch_err_q   <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
      fetch_err_q   <= fetch_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential/branch/jump next-PC, stall in HOLD, wrap, timeout fault.
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        pcsrc;
  logic        jump;
  logic [31:0] signimm;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        fetch_err;

  int checks;
  int failures;

  fetch_unit #(
    .RESET_PC       (32'h0000_0100),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pcsrc       (pcsrc),
    .jump        (jump),
    .signimm     (signimm),
    .pc          (pc),
    .pcplus4     (pcplus4),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expects FETCH with req up; zero-wait ack, instr visible after one edge.
  task automatic fetch_word(input string tag, input logic [31:0] exp_addr, input logic [31:0] word);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    chk({tag, "_addr"}, imem_addr, exp_addr);
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    chk({tag, "_vld"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "_instr"}, instr, word);
    chk({tag, "_req_low"}, {31'd0, imem_req}, 32'd0);
  endtask

  task automatic retire_with(input string tag, input logic p, input logic j,
                             input logic [31:0] imm, input logic [31:0] exp_pc);
    instr_ready = 1'b1;
    pcsrc       = p;
    jump        = j;
    signimm     = imm;
    step();
    instr_ready = 1'b0;
    pcsrc       = 1'b0;
    jump        = 1'b0;
    signimm     = 32'h0;
    chk({tag, "_pc"}, pc, exp_pc);
    chk({tag, "_vld_clr"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_req_new"}, {31'd0, imem_req}, 32'd1);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset_n     = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    pcsrc       = 1'b0;
    jump        = 1'b0;
    signimm     = 32'h0;

    // Reset state
    step();
    step();
    chk("rst_pc", pc, 32'h100);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_vld", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    reset_n = 1'b1;
    step();
    chk("rel_req", {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'h100);

    // Sequential fetch, ready held high throughout (no effect while invalid)
    instr_ready = 1'b1;
    fetch_word("seq0", 32'h100, 32'h2008_0005);
    chk("seq0_pcplus4", pcplus4, 32'h104);
    retire_with("seq0", 1'b0, 1'b0, 32'h0, 32'h104);
    fetch_word("seq1", 32'h104, 32'h2008_0005);
    retire_with("seq1", 1'b0, 1'b0, 32'h0, 32'h108);

    // Branch backward and forward from 0x108
    fetch_word("br0", 32'h108, 32'h1000_FFFE);
    retire_with("br_back", 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h104);
    fetch_word("br1", 32'h104, 32'h0000_0000);
    retire_with("br_seq", 1'b0, 1'b0, 32'h0, 32'h108);
    fetch_word("br2", 32'h108, 32'h1000_0003);
    retire_with("br_fwd", 1'b1, 1'b0, 32'h0000_0003, 32'h118);
    fetch_word("br3", 32'h118, 32'h1000_FFFA);
    retire_with("br_m6", 1'b1, 1'b0, 32'hFFFF_FFFA, 32'h104);

    // Jump, then jump beating a taken branch
    fetch_word("j0", 32'h104, 32'h0800_0040);
    retire_with("jump", 1'b0, 1'b1, 32'h0, 32'h100);
    fetch_word("j1", 32'h100, 32'h0000_0000);
    retire_with("j_seq", 1'b0, 1'b0, 32'h0, 32'h104);
    fetch_word("j2", 32'h104, 32'h0800_0040);
    retire_with("jump_prio", 1'b1, 1'b1, 32'h0000_0010, 32'h100);

    // Stall in HOLD with a spurious ack
    fetch_word("hold", 32'h100, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
      end
      step();
      chk("hold_instr", instr, 32'hDEAD_BEEF);
      chk("hold_pc", pc, 32'h100);
      chk("hold_vld", {31'd0, instr_valid}, 32'd1);
      chk("hold_req", {31'd0, imem_req}, 32'd0);
    end
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    retire_with("hold_out", 1'b0, 1'b0, 32'h0, 32'h104);

    // Branch to the top word, then wrap to zero
    fetch_word("wr0", 32'h104, 32'h1000_FFBD);
    retire_with("wr_top", 1'b1, 1'b0, 32'hFFFF_FFBD, 32'hFFFF_FFFC);
    fetch_word("wr1", 32'hFFFF_FFFC, 32'h0000_0000);
    chk("wr_pcplus4", pcplus4, 32'h0);
    retire_with("wrap", 1'b0, 1'b0, 32'h0, 32'h0);

    // Timeout: FETCH at 0 with no ack
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_wait_err", {31'd0, fetch_err}, 32'd0);
      chk("to_wait_req", {31'd0, imem_req}, 32'd1);
    end
    step();
    chk("to_err", {31'd0, fetch_err}, 32'd1);
    chk("to_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      imem_ack   = (i == 1);
      imem_rdata = 32'hCAFE_F00D;
      step();
      chk("err_sticky", {31'd0, fetch_err}, 32'd1);
      chk("err_req", {31'd0, imem_req}, 32'd0);
      chk("err_vld", {31'd0, instr_valid}, 32'd0);
    end

    // Reset pulse clears fault; a late ack at release is not captured
    reset_n = 1'b0;
    #1;
    chk("rr_err_async", {31'd0, fetch_err}, 32'd0);
    chk("rr_req_async", {31'd0, imem_req}, 32'd0);
    chk("rr_pc_async", pc, 32'h100);
    step();
    imem_ack = 1'b1;
    reset_n  = 1'b1;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    chk("rr_req", {31'd0, imem_req}, 32'd1);
    chk("rr_addr", imem_addr, 32'h100);
    chk("rr_no_capture", {31'd0, instr_valid}, 32'd0);
    fetch_word("rr_fetch", 32'h100, 32'h2008_0005);
    instr_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
